instr_encoder_loader: RTL and testbench

- Writer-side counterpart of the Grah-8 instruction decoder.
- Accepts decoded instruction fields over a valid/ready handshake and packs each one into the 8-bit Grah-8 instruction byte.
- Writes the packed bytes sequentially into program memory through a registered write port.
- Sits between the host/debug loader and program RAM; used to load programs before the CPU is released from reset.

---
 rtl/instr_encoder_loader.sv | 118 +++++++++++
 tb/tb_instr_encoder_loader.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// Grah-8 instruction encoder/loader.
// Packs decoded instruction fields into 8-bit Grah-8 bytes and streams them
// into program RAM through a registered write port, one byte per accepted
// instruction, starting from a base address captured at session start.
module instr_encoder_loader #(
  parameter int    UUID   = 0,
  parameter string NAME   = "",
  parameter int    ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_class,
  input  logic [5:0]        in_imm,
  input  logic [2:0]        in_src,
  input  logic [2:0]        in_dst,
  input  logic [2:0]        in_op,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   count
);

  // Identification parameters carry no logic; kept for instance bookkeeping.
  localparam int    UNUSED_UUID = UUID;
  localparam string UNUSED_NAME = NAME;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    FINISH = 2'd2
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [7:0]          mem_data_q;
  logic                overflow_q;
  logic [ADDR_W:0]     count_q;
  logic [7:0]          enc_d;
  logic                accept;

  assign accept = in_valid && (state_q == LOAD);

  // Pack the fields of the current instruction; class selects the layout.
  always_comb begin
    enc_d = {in_class, 6'b000000};
    case (in_class)
      2'b00:   enc_d[5:0] = in_imm;
      2'b01:   enc_d[5:0] = {in_src, in_dst};
      default: enc_d[2:0] = in_op;
    endcase
  end

  // Session FSM plus the registered memory write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      overflow_q <= 1'b0;
      count_q    <= '0;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= LOAD;
            addr_q     <= base_addr;
            count_q    <= '0;
            overflow_q <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            mem_we_q   <= 1'b1;
            mem_addr_q <= addr_q;
            mem_data_q <= enc_d;
            count_q    <= count_q + 1'b1;
            // Top of memory is a hard stop: the address never wraps.
            if (addr_q != ADDR_MAX) addr_q <= addr_q + 1'b1;
            if (in_last) begin
              state_q <= FINISH;
            end else if (addr_q == ADDR_MAX) begin
              overflow_q <= 1'b1;
              state_q    <= FINISH;
            end
          end
        end
        FINISH:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Status outputs are pure decodes of the state register.
  assign in_ready = (state_q == LOAD);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FINISH);
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign overflow = overflow_q;
  assign count    = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: an ADDR_W=8 instance for the main
// sessions and an ADDR_W=4 instance for the top-of-memory case.
module tb_instr_encoder_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, start4 = 1'b0;
  logic [7:0] base_addr = '0;
  logic [3:0] base_addr4 = '0;
  logic       in_valid = 1'b0;
  logic [1:0] in_class = '0;
  logic [5:0] in_imm = '0;
  logic [2:0] in_src = '0, in_dst = '0, in_op = '0;
  logic       in_last = 1'b0;

  logic       in_ready, mem_we, busy, done, overflow;
  logic [7:0] mem_addr, mem_data;
  logic [8:0] count;

  logic       in_ready4, mem_we4, busy4, done4, overflow4;
  logic [3:0] mem_addr4;
  logic [7:0] mem_data4;
  logic [4:0] count4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instr_encoder_loader #(.UUID(0), .NAME("u8"), .ADDR_W(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class),
    .in_imm(in_imm), .in_src(in_src), .in_dst(in_dst), .in_op(in_op),
    .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_data(mem_data), .busy(busy), .done(done), .overflow(overflow),
    .count(count)
  );

  instr_encoder_loader #(.UUID(1), .NAME("u4"), .ADDR_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .base_addr(base_addr4),
    .in_valid(in_valid), .in_ready(in_ready4), .in_class(in_class),
    .in_imm(in_imm), .in_src(in_src), .in_dst(in_dst), .in_op(in_op),
    .in_last(in_last), .mem_we(mem_we4), .mem_addr(mem_addr4),
    .mem_data(mem_data4), .busy(busy4), .done(done4), .overflow(overflow4),
    .count(count4)
  );

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_last = 1'b0; start = 1'b0; start4 = 1'b0;
    in_class = 2'b00; in_imm = '0; in_src = '0; in_dst = '0; in_op = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    tick();
    n_cmp++;
    if ({in_ready, mem_we, mem_addr, mem_data, busy, done, overflow, count} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got we=%b addr=%h data=%h busy=%b done=%b ovf=%b cnt=%0d rdy=%b, want all 0",
               mem_we, mem_addr, mem_data, busy, done, overflow, count, in_ready);
    end
    rst = 1'b1;
    in_valid = 1'b1;  // in_valid in IDLE must be ignored
    tick(); tick();
    n_cmp++;
    if (in_ready !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_valid_ignored: rdy=%b we=%b busy=%b, want 0 0 0", in_ready, mem_we, busy);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_single();
    start = 1'b1; base_addr = 8'h10;
    tick();
    start = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL single_enter_load: rdy=%b busy=%b, want 1 1", in_ready, busy);
    end
    in_valid = 1'b1; in_class = 2'b00; in_imm = 6'h2A; in_last = 1'b1;
    tick();
    idle_inputs();
    n_cmp++;
    if (mem_we !== 1'b1 || mem_addr !== 8'h10 || mem_data !== 8'h2A || done !== 1'b1 || count !== 9'd1) begin
      n_err++;
      $display("FAIL single_write: we=%b addr=%h data=%h done=%b cnt=%0d, want 1 10 2a 1 1",
               mem_we, mem_addr, mem_data, done, count);
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 8'h10 || mem_data !== 8'h2A) begin
      n_err++;
      $display("FAIL single_after: busy=%b done=%b we=%b addr=%h data=%h, want 0 0 0 10 2a",
               busy, done, mem_we, mem_addr, mem_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_data [3];
    exp_data[0] = 8'h5D; exp_data[1] = 8'h86; exp_data[2] = 8'hC2;
    start = 1'b1; base_addr = 8'h20;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      case (i)
        0: begin in_class = 2'b01; in_src = 3'd3; in_dst = 3'd5; in_op = 3'd7; in_imm = 6'h3F; end
        1: begin in_class = 2'b10; in_op = 3'd6; in_src = 3'd7; in_dst = 3'd7; end
        default: begin in_class = 2'b11; in_op = 3'd2; in_last = 1'b1; end
      endcase
      tick();
      n_cmp++;
      if (mem_we !== 1'b1 || mem_addr !== 8'h20 + 8'(i) || mem_data !== exp_data[i]) begin
        n_err++;
        $display("FAIL b2b_write%0d: we=%b addr=%h data=%h, want 1 %h %h",
                 i, mem_we, mem_addr, mem_data, 8'h20 + 8'(i), exp_data[i]);
      end
    end
    idle_inputs();
    n_cmp++;
    if (count !== 9'd3 || done !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_count: cnt=%0d done=%b, want 3 1", count, done);
    end
    tick();
  endtask

  task automatic test_stall();
    logic [4:0] pat;
    int nw;
    pat = 5'b10010;  // bit i = in_valid in cycle i: 0,1,0,0,1
    nw = 0;
    start = 1'b1; base_addr = 8'h40;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = pat[i]; in_class = 2'b00; in_imm = 6'(i + 1); in_last = (i == 4);
      tick();
      n_cmp++;
      if (mem_we !== pat[i] || (pat[i] && (mem_addr !== 8'h40 + 8'(nw) || mem_data !== 8'(i + 1)))) begin
        n_err++;
        $display("FAIL stall_cycle%0d: we=%b addr=%h data=%h, want we=%b addr=%h data=%h",
                 i, mem_we, mem_addr, mem_data, pat[i], 8'h40 + 8'(nw), 8'(i + 1));
      end
      if (pat[i]) nw++;
    end
    idle_inputs();
    n_cmp++;
    if (count !== 9'd2 || done !== 1'b1) begin
      n_err++;
      $display("FAIL stall_count: cnt=%0d done=%b, want 2 1", count, done);
    end
    tick();
  endtask

  task automatic test_overflow();
    start4 = 1'b1; base_addr4 = 4'hE;
    tick();
    start4 = 1'b0;
    in_valid = 1'b1; in_class = 2'b00; in_imm = 6'h01;
    tick();
    n_cmp++;
    if (mem_we4 !== 1'b1 || mem_addr4 !== 4'hE || mem_data4 !== 8'h01 || overflow4 !== 1'b0 || in_ready4 !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_first: we=%b addr=%h data=%h ovf=%b rdy=%b, want 1 e 01 0 1",
               mem_we4, mem_addr4, mem_data4, overflow4, in_ready4);
    end
    in_imm = 6'h02;
    tick();
    n_cmp++;
    if (mem_we4 !== 1'b1 || mem_addr4 !== 4'hF || mem_data4 !== 8'h02 || overflow4 !== 1'b1 ||
        done4 !== 1'b1 || in_ready4 !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_top: we=%b addr=%h data=%h ovf=%b done=%b rdy=%b, want 1 f 02 1 1 0",
               mem_we4, mem_addr4, mem_data4, overflow4, done4, in_ready4);
    end
    in_imm = 6'h03;  // third instruction stays offered but must not be taken
    tick();
    n_cmp++;
    if (mem_we4 !== 1'b0 || in_ready4 !== 1'b0 || busy4 !== 1'b0 || count4 !== 5'd2 ||
        overflow4 !== 1'b1 || mem_addr4 !== 4'hF) begin
      n_err++;
      $display("FAIL ovf_third_rejected: we=%b rdy=%b busy=%b cnt=%0d ovf=%b addr=%h, want 0 0 0 2 1 f",
               mem_we4, in_ready4, busy4, count4, overflow4, mem_addr4);
    end
    idle_inputs();
    start4 = 1'b1; base_addr4 = 4'h3;
    tick();
    start4 = 1'b0;
    n_cmp++;
    if (overflow4 !== 1'b0 || count4 !== 5'd0 || in_ready4 !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_cleared: ovf=%b cnt=%0d rdy=%b, want 0 0 1", overflow4, count4, in_ready4);
    end
    in_valid = 1'b1; in_class = 2'b10; in_op = 3'd1; in_last = 1'b1;
    tick();
    idle_inputs();
    n_cmp++;
    if (mem_we4 !== 1'b1 || mem_addr4 !== 4'h3 || mem_data4 !== 8'h81) begin
      n_err++;
      $display("FAIL ovf_new_session: we=%b addr=%h data=%h, want 1 3 81", mem_we4, mem_addr4, mem_data4);
    end
    tick();
  endtask

  task automatic test_start_ignored();
    start = 1'b1; base_addr = 8'h50;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_class = 2'b00; in_imm = 6'h11;
    tick();
    n_cmp++;
    if (mem_we !== 1'b1 || mem_addr !== 8'h50) begin
      n_err++;
      $display("FAIL start_ign_w0: we=%b addr=%h, want 1 50", mem_we, mem_addr);
    end
    start = 1'b1; base_addr = 8'h70; in_imm = 6'h12;
    tick();
    start = 1'b0;
    n_cmp++;
    if (mem_we !== 1'b1 || mem_addr !== 8'h51 || mem_data !== 8'h12) begin
      n_err++;
      $display("FAIL start_ign_w1: we=%b addr=%h data=%h, want 1 51 12", mem_we, mem_addr, mem_data);
    end
    in_imm = 6'h13; in_last = 1'b1;
    tick();
    idle_inputs();
    n_cmp++;
    if (mem_we !== 1'b1 || mem_addr !== 8'h52 || done !== 1'b1 || count !== 9'd3) begin
      n_err++;
      $display("FAIL start_ign_w2: we=%b addr=%h done=%b cnt=%0d, want 1 52 1 3", mem_we, mem_addr, done, count);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    start = 1'b1; base_addr = 8'h60;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_class = 2'b00; in_imm = 6'h05;
    tick();
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || mem_addr !== 8'h00 || count !== 9'd0) begin
      n_err++;
      $display("FAIL reset_mid: we=%b busy=%b rdy=%b addr=%h cnt=%0d, want 0 0 0 00 0",
               mem_we, busy, in_ready, mem_addr, count);
    end
    tick();
    rst = 1'b1;
    tick();
    n_cmp++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || mem_we !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release_idle: rdy=%b busy=%b we=%b, want 0 0 0", in_ready, busy, mem_we);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_overflow();
    test_start_ignored();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
